seg7_frame_decoder: RTL



---
 rtl/seg7_frame_decoder_if.sv | 40 ++++
 rtl/seg7_frame_decoder.sv | 136 +++++++++++++
 2 files changed

// File: rtl/seg7_frame_decoder_if.sv
// Bus bundle for the 7-segment frame decoder: a segment-beat input stream
// and a frame result output, each with its own valid/ready handshake.
interface seg7_frame_decoder_if #(
    parameter int NDIGITS = 3,
    parameter int BW      = 10
);
    logic                   seg_valid;
    logic                   seg_ready;
    logic [6:0]             seg_data;
    logic                   seg_first;
    logic                   out_valid;
    logic                   out_ready;
    logic [4*NDIGITS-1:0]   bcd_out;
    logic [BW-1:0]          bin_out;
    logic                   out_err;

    modport master (
        output seg_valid,
        output seg_data,
        output seg_first,
        output out_ready,
        input  seg_ready,
        input  out_valid,
        input  bcd_out,
        input  bin_out,
        input  out_err
    );

    modport slave (
        input  seg_valid,
        input  seg_data,
        input  seg_first,
        input  out_ready,
        output seg_ready,
        output out_valid,
        output bcd_out,
        output bin_out,
        output out_err
    );
endinterface

// File: rtl/seg7_frame_decoder.sv
// Decodes a stream of common-anode 7-segment codes (MSD first) back into an
// NDIGITS-digit frame, reported as packed BCD, binary, and an illegal-digit flag.
module seg7_frame_decoder #(
    parameter int NDIGITS = 3,
    parameter int BW      = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg7_frame_decoder_if.slave  bus
);
    localparam int BCDW = 4 * NDIGITS;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      count_q, count_d;
    logic [BCDW-1:0] bcd_acc_q, bcd_acc_d;
    logic [BW-1:0]   bin_acc_q, bin_acc_d;
    logic            err_acc_q, err_acc_d;
    logic            out_valid_q, out_valid_d;
    logic [BCDW-1:0] bcd_out_q, bcd_out_d;
    logic [BW-1:0]   bin_out_q, bin_out_d;
    logic            out_err_q, out_err_d;

    logic [3:0]      dig_nib;
    logic [3:0]      dig_val;
    logic            dig_bad;
    logic            accept;
    logic            frame_full;

    // Illegal and blank codes decode to nibble F and are flagged.
    always_comb begin
        dig_nib = 4'hF;
        dig_bad = 1'b1;
        case (bus.seg_data)
            7'b1000000: begin dig_nib = 4'd0; dig_bad = 1'b0; end
            7'b1111001: begin dig_nib = 4'd1; dig_bad = 1'b0; end
            7'b0100100: begin dig_nib = 4'd2; dig_bad = 1'b0; end
            7'b0110000: begin dig_nib = 4'd3; dig_bad = 1'b0; end
            7'b0011001: begin dig_nib = 4'd4; dig_bad = 1'b0; end
            7'b0010010: begin dig_nib = 4'd5; dig_bad = 1'b0; end
            7'b0000010: begin dig_nib = 4'd6; dig_bad = 1'b0; end
            7'b1111000: begin dig_nib = 4'd7; dig_bad = 1'b0; end
            7'b0000000: begin dig_nib = 4'd8; dig_bad = 1'b0; end
            7'b0010000: begin dig_nib = 4'd9; dig_bad = 1'b0; end
            default:    begin dig_nib = 4'hF; dig_bad = 1'b1; end
        endcase
    end

    assign dig_val       = dig_bad ? 4'd0 : dig_nib;
    assign bus.seg_ready = (state_q != DONE);
    assign accept        = bus.seg_valid & bus.seg_ready;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        bcd_acc_d   = bcd_acc_q;
        bin_acc_d   = bin_acc_q;
        err_acc_d   = err_acc_q;
        out_valid_d = out_valid_q;
        bcd_out_d   = bcd_out_q;
        bin_out_d   = bin_out_q;
        out_err_d   = out_err_q;
        frame_full  = 1'b0;

        case (state_q)
            IDLE, COLLECT: begin
                if (accept) begin
                    // An MSD beat always restarts, dropping any partial frame.
                    if (bus.seg_first) begin
                        bcd_acc_d = BCDW'(dig_nib);
                        bin_acc_d = BW'(dig_val);
                        err_acc_d = dig_bad;
                        count_d   = 3'd1;
                        state_d   = COLLECT;
                    end else if (state_q == COLLECT) begin
                        bcd_acc_d = (bcd_acc_q << 4) | BCDW'(dig_nib);
                        bin_acc_d = bin_acc_q * BW'(10) + BW'(dig_val);
                        err_acc_d = err_acc_q | dig_bad;
                        count_d   = count_q + 3'd1;
                    end
                    frame_full = (state_d == COLLECT) && (count_d == 3'(NDIGITS));
                end
                if (frame_full) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    bcd_out_d   = bcd_acc_d;
                    bin_out_d   = bin_acc_d;
                    out_err_d   = err_acc_d;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= 3'd0;
            bcd_acc_q   <= '0;
            bin_acc_q   <= '0;
            err_acc_q   <= 1'b0;
            out_valid_q <= 1'b0;
            bcd_out_q   <= '0;
            bin_out_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            bcd_acc_q   <= bcd_acc_d;
            bin_acc_q   <= bin_acc_d;
            err_acc_q   <= err_acc_d;
            out_valid_q <= out_valid_d;
            bcd_out_q   <= bcd_out_d;
            bin_out_q   <= bin_out_d;
            out_err_q   <= out_err_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.bcd_out   = bcd_out_q;
    assign bus.bin_out   = bin_out_q;
    assign bus.out_err   = out_err_q;
endmodule
